// File: rtl/logic_probe_ctrl_if.sv
// Result port bundle for logic_probe_ctrl.
//   res_valid  : result word valid (driven by the controller)
//   res_ready  : consumer accepts the word (driven by the consumer)
//   res_data   : counter value, CW bits
//   res_index  : counter index 0=low 1=high 2=z 3=freq_low 4=freq_high 5=freq_rs
// CW must equal the controller's COUNTERS_WIDTH.
interface logic_probe_ctrl_if #(
  parameter int unsigned CW = 28
);
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_data;
  logic [2:0]    res_index;

  modport master (
    output res_valid,
    output res_data,
    output res_index,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_index,
    output res_ready
  );
endinterface

// File: rtl/logic_probe_ctrl.sv
// Sequencer for the logic-probe counter block.
// Opens a measurement window by pulsing probe_interrupt_clear, waits for the
// probe's end-of-window probe_interrupt, then toggles probe_clk_in to shift the
// six counters out bit-serially (MSB first).  Each counter is presented as a
// parallel word on the valid/ready result interface.
// Ports:
//   clk, nreset            clock, synchronous active-low reset
//   start                  request one measurement (sampled only in IDLE)
//   busy                   high in every state except IDLE
//   probe_interrupt        end-of-window flag from the probe
//   probe_data             serial MSB-first data from the probe
//   probe_clk_in           shift clock to the probe
//   probe_interrupt_clear  one-cycle window restart to the probe
//   res                    result interface (master): res_valid/res_ready/res_data/res_index
// Build option: define LOGIC_PROBE_CTRL_CONTINUOUS_EN to make DONE reopen the
// next window automatically (measurements repeat until nreset).
module logic_probe_ctrl #(
  parameter int unsigned COUNTERS_WIDTH = 28,
  parameter int unsigned SHIFT_DIV      = 4,
  parameter int unsigned IRQ_SETTLE     = 2
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 start,
  output logic                 busy,
  input  logic                 probe_interrupt,
  input  logic                 probe_data,
  output logic                 probe_clk_in,
  output logic                 probe_interrupt_clear,
  logic_probe_ctrl_if.master   res
);

  localparam int unsigned CW = COUNTERS_WIDTH;
  localparam int unsigned BW = $clog2(CW + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_IRQ,
    SAMPLE,
    SHIFT_HI,
    SHIFT_LO,
    EMIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] shreg;
  logic [CW-1:0] sampled;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    word_cnt;
  logic [7:0]    div_cnt;
  logic [7:0]    settle_cnt;
  logic          skip_irq;
  logic          irq_seen;

  assign sampled = {shreg[CW-2:0], probe_data};

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state                 <= IDLE;
      busy                  <= 1'b0;
      probe_clk_in          <= 1'b0;
      probe_interrupt_clear <= 1'b0;
      res.res_valid         <= 1'b0;
      res.res_data          <= '0;
      res.res_index         <= '0;
      shreg                 <= '0;
      bit_cnt               <= '0;
      word_cnt              <= '0;
      div_cnt               <= '0;
      settle_cnt            <= '0;
      skip_irq              <= 1'b0;
      irq_seen              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state                 <= ARM;
            busy                  <= 1'b1;
            probe_interrupt_clear <= 1'b1;
          end
        end

        ARM: begin
          probe_interrupt_clear <= 1'b0;
          skip_irq              <= 1'b1;
          irq_seen              <= 1'b0;
          state                 <= WAIT_IRQ;
        end

        // First cycle is skipped: the probe has not yet acted on the clear and
        // may still show the previous window's interrupt.  After the interrupt
        // is seen, settle_cnt runs IRQ_SETTLE cycles for the parallel load.
        WAIT_IRQ: begin
          if (skip_irq) begin
            skip_irq <= 1'b0;
          end else if (!irq_seen) begin
            if (probe_interrupt) begin
              if (IRQ_SETTLE == 0) begin
                state <= SAMPLE;
              end else begin
                irq_seen   <= 1'b1;
                settle_cnt <= 8'(IRQ_SETTLE);
              end
            end
          end else if (settle_cnt == 8'd1) begin
            irq_seen <= 1'b0;
            state    <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end

        SAMPLE: begin
          shreg   <= sampled;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(CW - 1)) begin
            state         <= EMIT;
            res.res_valid <= 1'b1;
            res.res_data  <= sampled;
            res.res_index <= word_cnt;
          end else begin
            state        <= SHIFT_HI;
            probe_clk_in <= 1'b1;
            div_cnt      <= '0;
          end
        end

        SHIFT_HI: begin
          if (div_cnt == 8'(SHIFT_DIV - 1)) begin
            state        <= SHIFT_LO;
            probe_clk_in <= 1'b0;
            div_cnt      <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        SHIFT_LO: begin
          if (div_cnt == 8'(SHIFT_DIV - 1)) begin
            state   <= SAMPLE;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        // The shift pulse leaving EMIT moves out the last bit of the word just
        // accepted, so the probe is left untouched while the consumer stalls.
        EMIT: begin
          if (res.res_ready) begin
            res.res_valid <= 1'b0;
            word_cnt      <= word_cnt + 3'd1;
            bit_cnt       <= '0;
            if (word_cnt == 3'd5) begin
              state                 <= DONE;
              probe_interrupt_clear <= 1'b1;
            end else begin
              state        <= SHIFT_HI;
              probe_clk_in <= 1'b1;
              div_cnt      <= '0;
            end
          end
        end

        DONE: begin
          probe_interrupt_clear <= 1'b0;
          word_cnt              <= '0;
`ifdef LOGIC_PROBE_CTRL_CONTINUOUS_EN
          skip_irq              <= 1'b1;
          irq_seen              <= 1'b0;
          state                 <= WAIT_IRQ;
`else
          busy                  <= 1'b0;
          state                 <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_probe_ctrl.sv
// Self-checking bench for logic_probe_ctrl with a behavioural probe model
// (CW=8, SHIFT_DIV=2, IRQ_SETTLE=2).
module tb_logic_probe_ctrl;

  localparam int CW    = 8;
  localparam int SD    = 2;
  localparam int IS    = 2;
  localparam int WIN   = 6;
  localparam int LIMIT = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset;
  logic start;
  logic busy;
  logic probe_interrupt;
  logic probe_data;
  logic probe_clk_in;
  logic probe_interrupt_clear;

  logic_probe_ctrl_if #(.CW(CW)) res_if ();

  logic_probe_ctrl #(
    .COUNTERS_WIDTH(CW),
    .SHIFT_DIV(SD),
    .IRQ_SETTLE(IS)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .start(start),
    .busy(busy),
    .probe_interrupt(probe_interrupt),
    .probe_data(probe_data),
    .probe_clk_in(probe_clk_in),
    .probe_interrupt_clear(probe_interrupt_clear),
    .res(res_if)
  );

  // Probe model: a clear restarts a WIN-cycle window; at its end the six
  // counters are loaded into one long shift register and the interrupt raised.
  // The shift register advances on each registered rising edge of clk_in.
  logic [CW-1:0]   cnt_val [6];
  logic [6*CW-1:0] psh;
  logic            clk_d;
  int              win;

  always @(posedge clk) begin
    if (!nreset) begin
      psh             <= '0;
      clk_d           <= 1'b0;
      win             <= 0;
      probe_interrupt <= 1'b0;
    end else begin
      clk_d <= probe_clk_in;
      if (probe_interrupt_clear) begin
        probe_interrupt <= 1'b0;
        win             <= WIN;
      end else if (win > 0) begin
        if (win == 1) begin
          probe_interrupt <= 1'b1;
          psh <= {cnt_val[0], cnt_val[1], cnt_val[2], cnt_val[3], cnt_val[4], cnt_val[5]};
        end
        win <= win - 1;
      end else if (probe_clk_in && !clk_d) begin
        psh <= psh << 1;
      end
    end
  end

  assign probe_data = psh[6*CW-1];

  // Monitor: records accepted words and counts shift pulses and clear cycles.
  logic [CW-1:0] rx_d [$];
  logic [2:0]    rx_i [$];
  int            pulses;
  int            clears;
  logic          prev_ck;

  always @(negedge clk) begin
    if (nreset && res_if.res_valid && res_if.res_ready) begin
      rx_d.push_back(res_if.res_data);
      rx_i.push_back(res_if.res_index);
    end
    if (probe_clk_in && !prev_ck) pulses = pulses + 1;
    prev_ck = probe_clk_in;
    if (probe_interrupt_clear) clears = clears + 1;
  end

  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic all_outputs_zero(input string tag);
    check(tag, 64'({busy, probe_clk_in, probe_interrupt_clear, res_if.res_valid,
                    res_if.res_data, res_if.res_index}), 64'd0);
  endtask

  task automatic set_counters(input logic [CW-1:0] a, b, c, d, e, f);
    cnt_val[0] = a; cnt_val[1] = b; cnt_val[2] = c;
    cnt_val[3] = d; cnt_val[4] = e; cnt_val[5] = f;
  endtask

  task automatic random_counters();
    for (int i = 0; i < 6; i++) cnt_val[i] = CW'($urandom);
  endtask

  // One measurement (nwin windows in continuous builds), checked against the
  // counters loaded into the probe model.
  task automatic run(input int nwin, input bit rnd_ready, input bit bp, input bit spam_start);
    int rb, pb, cb, got;
    bit seen_busy, finished, bp_done;
    rb = rx_d.size(); pb = pulses; cb = clears;
    seen_busy = 0; finished = 0; bp_done = 0;
    res_if.res_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < LIMIT && !finished; c++) begin
      @(posedge clk); #1;
      if (busy) seen_busy = 1;
      start = spam_start && busy && ($urandom_range(2) == 0);
      if (bp && !bp_done && res_if.res_valid && res_if.res_index == 3'd2) begin
        res_if.res_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          check("bp_valid", 64'(res_if.res_valid), 64'd1);
          check("bp_data", 64'(res_if.res_data), 64'(cnt_val[2]));
          check("bp_index", 64'(res_if.res_index), 64'd2);
          check("bp_clk_low", 64'(probe_clk_in), 64'd0);
        end
        res_if.res_ready = 1'b1;
        bp_done = 1;
      end else if (rnd_ready) begin
        res_if.res_ready = ($urandom_range(3) != 0);
      end
`ifdef LOGIC_PROBE_CTRL_CONTINUOUS_EN
      if (rx_d.size() - rb >= 6 * nwin && clears - cb >= nwin + 1) finished = 1;
`else
      if (seen_busy && !busy) finished = 1;
`endif
    end
    start = 1'b0;
    res_if.res_ready = 1'b1;
    check("run_done", 64'(finished), 64'd1);
`ifdef LOGIC_PROBE_CTRL_CONTINUOUS_EN
    check("busy_running", 64'(busy), 64'd1);
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
`else
    repeat (6) @(posedge clk);
    #1;
    check("busy_end", 64'(busy), 64'd0);
`endif
    got = rx_d.size() - rb;
    check("word_count", 64'(got), 64'(6 * nwin));
    for (int i = 0; i < got && i < 6 * nwin; i++) begin
      check($sformatf("word%0d_data", i), 64'(rx_d[rb + i]), 64'(cnt_val[i % 6]));
      check($sformatf("word%0d_index", i), 64'(rx_i[rb + i]), 64'(i % 6));
    end
    check("shift_pulses", 64'(pulses - pb), 64'(nwin * (6 * CW - 1)));
    check("clear_pulses", 64'(clears - cb), 64'(nwin + 1));
  endtask

  initial begin
    int rb, pb, cb;
    bit hit;
    n_cmp = 0; n_err = 0;
    nreset = 1'b0;
    start  = 1'b1;
    res_if.res_ready = 1'b0;
    set_counters(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset held with start asserted.
    cb = clears;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      all_outputs_zero($sformatf("reset_outputs_%0d", i));
    end
    check("reset_no_clear", 64'(clears - cb), 64'd0);
    start = 1'b0;
    nreset = 1'b1;
    @(posedge clk); #1;
    all_outputs_zero("idle_after_reset");

    // Single run, ready tied high.
    set_counters(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    run(1, 0, 0, 0);

    // Backpressure on word 2.
    run(1, 0, 1, 0);

    // MSB/LSB patterns.
    set_counters(8'hFF, 8'h00, 8'h80, 8'h01, 8'hA5, 8'h5A);
    run(1, 0, 0, 0);

    // Reset during bit 3 of word 1, then a fresh run.
    random_counters();
    rb = rx_d.size(); pb = pulses; hit = 0;
    res_if.res_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < LIMIT && !hit; c++) begin
      @(posedge clk); #1;
      if (pulses - pb >= CW + 3) hit = 1;
    end
    check("midreset_reached", 64'(hit), 64'd1);
    check("midreset_in_shift", 64'(probe_clk_in), 64'd1);
    nreset = 1'b0;
    @(posedge clk); #1;
    all_outputs_zero("midreset_outputs");
    check("midreset_words", 64'(rx_d.size() - rb), 64'd1);
    if (rx_d.size() > rb) check("midreset_word0", 64'(rx_d[rb]), 64'(cnt_val[0]));
    @(posedge clk); #1 nreset = 1'b1;
    @(posedge clk); #1;
    all_outputs_zero("midreset_idle");
    random_counters();
    run(1, 1, 0, 0);

`ifdef LOGIC_PROBE_CTRL_CONTINUOUS_EN
    // Three back-to-back windows from a single start.
    random_counters();
    run(3, 1, 0, 0);
`else
    // start pulsed while busy is ignored.
    random_counters();
    run(1, 0, 0, 1);
`endif

    // Randomized counters and consumer backpressure.
    for (int r = 0; r < 3; r++) begin
      random_counters();
      run(1, 1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
